// File: rtl/pcpu_pkg.sv
// pcpu_pkg -- shared definitions for the pcpu control path.
//
// Contents:
//   - instruction-register field positions
//   - opcode constants
//   - sequencer state encoding
//   - default ALU mode codes used by the control path
//   - reg_onehot(): register index to one-hot write enable
package pcpu_pkg;

  // Instruction register field positions
  localparam int OP_LSB   = 0;   // op   = IR[3:0]
  localparam int FUNC_LSB = 4;   // func = IR[7:4]
  localparam int RD_LSB   = 8;   // rd   = IR[10:8]
  localparam int RS_LSB   = 11;  // rs   = IR[13:11]
  localparam int C_BIT    = 14;  // c    = IR[14]
  localparam int IMM_LSB  = 16;  // imm  = IR[31:16]; IR[15] is reserved

  // Opcodes; 4'h9..4'hF are illegal
  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ALU_RR = 4'h1;
  localparam logic [3:0] OP_ALU_RI = 4'h2;
  localparam logic [3:0] OP_LDI    = 4'h3;
  localparam logic [3:0] OP_LD     = 4'h4;
  localparam logic [3:0] OP_ST     = 4'h5;
  localparam logic [3:0] OP_JMP    = 4'h6;
  localparam logic [3:0] OP_JCC    = 4'h7;
  localparam logic [3:0] OP_HALT   = 4'h8;

  // Default ALU mode codes
  localparam logic [3:0] ALU_ADD_DEF    = 4'h0;
  localparam logic [3:0] ALU_PASS_R_DEF = 4'hF;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  function automatic logic [7:0] reg_onehot(input logic [2:0] idx);
    return 8'(1) << idx;
  endfunction

endpackage

// File: rtl/cpu_decode.sv
// cpu_decode -- combinational control decode for the pcpu sequencer.
//
// Maps the sequencer state, the latched instruction fields and the
// data-memory handshake status onto every datapath control line.
//
// Ports:
//   state           in   3  current sequencer state (pcpu_pkg::state_e)
//   ir              in  15  latched IR[14:0] (op, func, rd, rs, c)
//   flags_q         in   8  ALU flags latched by the last ALU instruction
//   mem_ack         in   1  data access complete
//   mem_timeout     in   1  last permitted MEM cycle without ack
//   instr_req       out  1  fetch request
//   mem_req/mem_we  out  1  data access request / write
//   pc_inc/pc_ie    out  1  PC increment / PC load from ALU bus
//   reg_in_mux_ctl  out  1  1 = memory data to register file
//   alu_r_mux_ctl   out  1  1 = immediate to ALU right operand
//   alu_cin         out  1  ALU carry-in
//   alu_mode        out  4  ALU operation
//   reg_l_ctl       out  4  left register select
//   reg_r_ctl       out  4  right register select
//   gp_reg_ie       out  8  one-hot register write enable
module cpu_decode
  import pcpu_pkg::*;
#(
  parameter logic [3:0] ALU_ADD    = ALU_ADD_DEF,
  parameter logic [3:0] ALU_PASS_R = ALU_PASS_R_DEF,
  parameter int         CARRY_BIT  = 0
) (
  input  logic [2:0]  state,
  input  logic [14:0] ir,
  input  logic [7:0]  flags_q,
  input  logic        mem_ack,
  input  logic        mem_timeout,
  output logic        instr_req,
  output logic        mem_req,
  output logic        mem_we,
  output logic        pc_inc,
  output logic        pc_ie,
  output logic        reg_in_mux_ctl,
  output logic        alu_r_mux_ctl,
  output logic        alu_cin,
  output logic [3:0]  alu_mode,
  output logic [3:0]  reg_l_ctl,
  output logic [3:0]  reg_r_ctl,
  output logic [7:0]  gp_reg_ie
);

  logic [3:0] op;
  logic [3:0] func;
  logic [2:0] rd;
  logic [2:0] rs;
  logic       c;
  logic       is_ld;
  logic       is_st;
  logic       mem_phase;
  logic       jcc_taken;
  logic       carry_in;

  assign op   = ir[OP_LSB   +: 4];
  assign func = ir[FUNC_LSB +: 4];
  assign rd   = ir[RD_LSB   +: 3];
  assign rs   = ir[RS_LSB   +: 3];
  assign c    = ir[C_BIT];

  assign is_ld = (op == OP_LD);
  assign is_st = (op == OP_ST);

  // The address computation and bus request are identical in EXEC and
  // every MEM cycle, so the datapath sees stable controls for the whole
  // access.
  assign mem_phase = ((state == ST_EXEC) && (is_ld || is_st)) || (state == ST_MEM);

  // c inverts the sense of the selected flag.
  assign jcc_taken = flags_q[func[2:0]] ^ c;
  assign carry_in  = c & flags_q[CARRY_BIT];

  always_comb begin
    instr_req      = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    pc_inc         = 1'b0;
    pc_ie          = 1'b0;
    reg_in_mux_ctl = 1'b0;
    alu_r_mux_ctl  = 1'b0;
    alu_cin        = 1'b0;
    alu_mode       = 4'h0;
    reg_l_ctl      = 4'h0;
    reg_r_ctl      = 4'h0;
    gp_reg_ie      = 8'h00;

    case (state)
      ST_FETCH: instr_req = 1'b1;

      ST_EXEC: begin
        case (op)
          OP_NOP: pc_inc = 1'b1;
          OP_ALU_RR: begin
            alu_mode  = func;
            reg_l_ctl = {1'b0, rd};
            reg_r_ctl = {1'b0, rs};
            alu_cin   = carry_in;
            gp_reg_ie = reg_onehot(rd);
            pc_inc    = 1'b1;
          end
          OP_ALU_RI: begin
            alu_mode      = func;
            reg_l_ctl     = {1'b0, rs};
            alu_r_mux_ctl = 1'b1;
            alu_cin       = carry_in;
            gp_reg_ie     = reg_onehot(rd);
            pc_inc        = 1'b1;
          end
          OP_LDI: begin
            alu_mode      = ALU_PASS_R;
            alu_r_mux_ctl = 1'b1;
            gp_reg_ie     = reg_onehot(rd);
            pc_inc        = 1'b1;
          end
          OP_LD, OP_ST: ;  // handled by the address-phase block below
          OP_JMP: begin
            alu_mode      = ALU_ADD;
            alu_r_mux_ctl = 1'b1;
            reg_l_ctl     = {1'b0, rs};
            pc_ie         = 1'b1;
          end
          OP_JCC: begin
            alu_mode      = ALU_ADD;
            alu_r_mux_ctl = 1'b1;
            reg_l_ctl     = {1'b0, rs};
            pc_ie         = jcc_taken;
            pc_inc        = !jcc_taken;
          end
          OP_HALT: ;
          default: pc_inc = 1'b1;  // illegal opcode behaves as NOP
        endcase
      end

      ST_MEM: begin
        // Ack wins over a coincident timeout; a timed-out access skips the
        // register write but still advances the PC.
        if (mem_ack) begin
          pc_inc = 1'b1;
          if (is_ld) begin
            gp_reg_ie      = reg_onehot(rd);
            reg_in_mux_ctl = 1'b1;
          end
        end else if (mem_timeout) begin
          pc_inc = 1'b1;
        end
      end

      default: ;  // BOOT and HALT drive nothing
    endcase

    if (mem_phase) begin
      alu_mode      = ALU_ADD;
      alu_r_mux_ctl = 1'b1;
      reg_l_ctl     = {1'b0, rs};
      reg_r_ctl     = is_st ? {1'b0, rd} : 4'h0;
      mem_req       = 1'b1;
      mem_we        = is_st;
    end
  end

endmodule

// File: rtl/cpu_control.sv
// cpu_control -- multi-cycle sequencer for the 16-bit pcpu datapath.
//
// Fetches a 32-bit instruction over a req/ack port, latches it, and
// drives all datapath controls through cpu_decode. Holds the sequencer
// state, the instruction register, the ALU flag latch, the data-memory
// wait counter and the sticky status bits.
//
// Ports:
//   clk             in   1  clock, rising edge
//   rst             in   1  asynchronous active-low reset
//   instr_req       out  1  fetch request at current PC
//   instr_ack       in   1  instruction valid this cycle
//   instr           in  32  instruction word
//   alu_flags       in   8  combinational ALU flags
//   mem_req/mem_we  out  1  data access request / write
//   mem_ack         in   1  data access complete
//   pc_inc/pc_ie    out  1  PC +1 / PC load from ALU bus
//   reg_in_mux_ctl  out  1  1 = memory data to register file
//   alu_r_mux_ctl   out  1  1 = immediate to ALU right operand
//   alu_cin         out  1  ALU carry-in
//   alu_mode        out  4  ALU operation
//   reg_l_ctl       out  4  left register select
//   reg_r_ctl       out  4  right register select
//   gp_reg_ie       out  8  one-hot register write enable
//   imm             out 16  latched IR[31:16]
//   halted          out  1  sticky: HALT executed
//   err_illegal     out  1  sticky: illegal opcode executed
//   err_bus         out  1  sticky: data access timed out
module cpu_control
  import pcpu_pkg::*;
#(
  parameter logic [3:0] ALU_ADD     = ALU_ADD_DEF,
  parameter logic [3:0] ALU_PASS_R  = ALU_PASS_R_DEF,
  parameter int         CARRY_BIT   = 0,
  parameter int         MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        instr_req,
  input  logic        instr_ack,
  input  logic [31:0] instr,
  input  logic [7:0]  alu_flags,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        pc_inc,
  output logic        pc_ie,
  output logic        reg_in_mux_ctl,
  output logic        alu_r_mux_ctl,
  output logic        alu_cin,
  output logic [3:0]  alu_mode,
  output logic [3:0]  reg_l_ctl,
  output logic [3:0]  reg_r_ctl,
  output logic [7:0]  gp_reg_ie,
  output logic [15:0] imm,
  output logic        halted,
  output logic        err_illegal,
  output logic        err_bus
);

  state_e      state_q;
  logic [31:0] ir_q;
  logic [7:0]  flags_q;
  logic [7:0]  wait_cnt_q;
  logic        halted_q;
  logic        err_illegal_q;
  logic        err_bus_q;
  logic [3:0]  op;
  logic        mem_timeout;
  logic        unused_ir_rsvd;

  assign op             = ir_q[OP_LSB +: 4];
  assign unused_ir_rsvd = ir_q[15];

  // wait_cnt_q counts MEM cycles already spent, so the MEM_TIMEOUT-th
  // MEM cycle is the last one that can still accept an ack.
  assign mem_timeout = (state_q == ST_MEM) && (wait_cnt_q == 8'(MEM_TIMEOUT - 1));

  assign imm         = ir_q[IMM_LSB +: 16];
  assign halted      = halted_q;
  assign err_illegal = err_illegal_q;
  assign err_bus     = err_bus_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_BOOT;
      ir_q          <= '0;
      flags_q       <= '0;
      wait_cnt_q    <= '0;
      halted_q      <= 1'b0;
      err_illegal_q <= 1'b0;
      err_bus_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_BOOT: state_q <= ST_FETCH;

        ST_FETCH: begin
          if (instr_ack) begin
            ir_q    <= instr;
            state_q <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          state_q <= ST_FETCH;
          case (op)
            OP_ALU_RR, OP_ALU_RI: flags_q <= alu_flags;
            OP_LD, OP_ST: begin
              wait_cnt_q <= '0;
              state_q    <= ST_MEM;
            end
            OP_HALT: begin
              halted_q <= 1'b1;
              state_q  <= ST_HALT;
            end
            OP_NOP, OP_LDI, OP_JMP, OP_JCC: ;
            default: err_illegal_q <= 1'b1;
          endcase
        end

        ST_MEM: begin
          if (mem_ack) begin
            state_q <= ST_FETCH;
          end else if (mem_timeout) begin
            err_bus_q <= 1'b1;
            state_q   <= ST_FETCH;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end

        ST_HALT: ;  // only reset leaves HALT

        default: state_q <= ST_BOOT;
      endcase
    end
  end

  cpu_decode #(
    .ALU_ADD    (ALU_ADD),
    .ALU_PASS_R (ALU_PASS_R),
    .CARRY_BIT  (CARRY_BIT)
  ) u_decode (
    .state          (state_q),
    .ir             (ir_q[14:0]),
    .flags_q        (flags_q),
    .mem_ack        (mem_ack),
    .mem_timeout    (mem_timeout),
    .instr_req      (instr_req),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .pc_inc         (pc_inc),
    .pc_ie          (pc_ie),
    .reg_in_mux_ctl (reg_in_mux_ctl),
    .alu_r_mux_ctl  (alu_r_mux_ctl),
    .alu_cin        (alu_cin),
    .alu_mode       (alu_mode),
    .reg_l_ctl      (reg_l_ctl),
    .reg_r_ctl      (reg_r_ctl),
    .gp_reg_ie      (gp_reg_ie)
  );

endmodule

// File: tb/tb_cpu_control.sv
// Testbench for cpu_control: table of instructions executed one after the
// other, expectations queued when each instruction is fetched and compared
// when the instruction retires (pc_inc/pc_ie), plus hand-written sequences
// for reset, mid-access reset and HALT.
module tb_cpu_control;

  logic        clk;
  logic        rst;
  logic        instr_req;
  logic        instr_ack;
  logic [31:0] instr;
  logic [7:0]  alu_flags;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack;
  logic        pc_inc;
  logic        pc_ie;
  logic        reg_in_mux_ctl;
  logic        alu_r_mux_ctl;
  logic        alu_cin;
  logic [3:0]  alu_mode;
  logic [3:0]  reg_l_ctl;
  logic [3:0]  reg_r_ctl;
  logic [7:0]  gp_reg_ie;
  logic [15:0] imm;
  logic        halted;
  logic        err_illegal;
  logic        err_bus;

  cpu_control #(
    .ALU_ADD     (4'h0),
    .ALU_PASS_R  (4'hF),
    .CARRY_BIT   (0),
    .MEM_TIMEOUT (15)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .instr_req      (instr_req),
    .instr_ack      (instr_ack),
    .instr          (instr),
    .alu_flags      (alu_flags),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_ack        (mem_ack),
    .pc_inc         (pc_inc),
    .pc_ie          (pc_ie),
    .reg_in_mux_ctl (reg_in_mux_ctl),
    .alu_r_mux_ctl  (alu_r_mux_ctl),
    .alu_cin        (alu_cin),
    .alu_mode       (alu_mode),
    .reg_l_ctl      (reg_l_ctl),
    .reg_r_ctl      (reg_r_ctl),
    .gp_reg_ie      (gp_reg_ie),
    .imm            (imm),
    .halted         (halted),
    .err_illegal    (err_illegal),
    .err_bus        (err_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] outs;
  assign outs = {17'b0, instr_req, mem_req, mem_we, pc_inc, pc_ie, reg_in_mux_ctl,
                 alu_r_mux_ctl, alu_cin, alu_mode, reg_l_ctl, reg_r_ctl, gp_reg_ie,
                 imm, halted, err_illegal, err_bus};

  typedef struct packed {
    logic [31:0] instr;
    logic [7:0]  flags;    // alu_flags presented while the instruction runs
    logic [7:0]  ack_mem;  // MEM cycle (1-based) that gets mem_ack; 0 = never
    logic        chk_alu;  // compare mode/rmux/cin in EXEC
    logic [3:0]  mode;
    logic        rmux;
    logic        cin;
    logic [1:0]  chk_lr;   // [1]: compare reg_l_ctl, [0]: compare reg_r_ctl
    logic [3:0]  l;
    logic [3:0]  r;
    logic [7:0]  we;       // OR of gp_reg_ie over the instruction
    logic        memin;    // a register write took memory data
    logic        mwe;      // mem_we seen
    logic [7:0]  mreq;     // cycles with mem_req high
    logic        inc;
    logic        ie;
    logic [7:0]  cyc;      // cycles from fetch-ack cycle to retire, inclusive
  } vec_t;

  localparam int NV = 13;
  vec_t tbl[NV];
  vec_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] fn,
                                      input logic [2:0] rd, input logic [2:0] rs,
                                      input logic c, input logic [15:0] im);
    return {im, 1'b0, c, rs, rd, fn, op};
  endfunction

  function automatic vec_t mk(input logic [31:0] ins, input logic [7:0] flags, input int ack,
                              input logic chk_alu, input logic [3:0] mode, input logic rmux,
                              input logic cin, input logic [1:0] chk_lr, input logic [3:0] l,
                              input logic [3:0] r, input logic [7:0] we, input logic memin,
                              input logic mwe, input int mreq, input logic inc, input logic ie,
                              input int cyc);
    vec_t v;
    v.instr = ins;  v.flags = flags;  v.ack_mem = 8'(ack);
    v.chk_alu = chk_alu;  v.mode = mode;  v.rmux = rmux;  v.cin = cin;
    v.chk_lr = chk_lr;  v.l = l;  v.r = r;
    v.we = we;  v.memin = memin;  v.mwe = mwe;  v.mreq = 8'(mreq);
    v.inc = inc;  v.ie = ie;  v.cyc = 8'(cyc);
    return v;
  endfunction

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (instr_req) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL fetch_wait: instr_req=0 after 20 cycles, required 1");
    end
  endtask

  task automatic release_rst();
    @(posedge clk); #1;
    rst       = 1'b1;
    instr_ack = 1'b0;
    mem_ack   = 1'b0;
    @(negedge clk); #1;
    chk("boot_instr_req", 64'(instr_req), 64'd0);
    @(negedge clk); #1;
    chk("first_instr_req", 64'(instr_req), 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit         ok;
    bit         done;
    int         cyc;
    int         mreq;
    logic [7:0] we;
    logic       memin, mwe, inc, ie, rmux, cin;
    logic [3:0] mode, l, r;
    vec_t       e;
    wait_req(ok);
    if (!ok) return;
    instr     = v.instr;
    instr_ack = 1'b1;
    alu_flags = v.flags;
    exp_q.push_back(v);
    done = 0; cyc = 1; mreq = 0; we = '0; memin = 0; mwe = 0;
    inc = 0; ie = 0; rmux = 0; cin = 0; mode = '0; l = '0; r = '0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      instr_ack = 1'b0;
      @(negedge clk);
      cyc++;
      if (mem_req) mreq++;
      mem_ack = mem_req && (v.ack_mem != 8'd0) && (mreq == int'(v.ack_mem) + 1);
      #1;
      if (cyc == 2) begin
        mode = alu_mode; rmux = alu_r_mux_ctl; cin = alu_cin; l = reg_l_ctl; r = reg_r_ctl;
      end
      we    |= gp_reg_ie;
      memin |= reg_in_mux_ctl && (gp_reg_ie != 8'h00);
      mwe   |= mem_we;
      if (pc_inc || pc_ie) begin
        done = 1; inc = pc_inc; ie = pc_ie;
      end
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    e = exp_q.pop_front();
    chk($sformatf("v%0d_retired", idx), 64'(done), 64'd1);
    chk($sformatf("v%0d_pc_inc", idx), 64'(inc), 64'(e.inc));
    chk($sformatf("v%0d_pc_ie", idx), 64'(ie), 64'(e.ie));
    chk($sformatf("v%0d_gp_reg_ie", idx), 64'(we), 64'(e.we));
    chk($sformatf("v%0d_reg_in_mux", idx), 64'(memin), 64'(e.memin));
    chk($sformatf("v%0d_mem_we", idx), 64'(mwe), 64'(e.mwe));
    chk($sformatf("v%0d_mem_req_cycles", idx), 64'(mreq), 64'(e.mreq));
    chk($sformatf("v%0d_cycles", idx), 64'(cyc), 64'(e.cyc));
    chk($sformatf("v%0d_imm", idx), 64'(imm), 64'(e.instr[31:16]));
    if (e.chk_alu) begin
      chk($sformatf("v%0d_alu_mode", idx), 64'(mode), 64'(e.mode));
      chk($sformatf("v%0d_alu_r_mux", idx), 64'(rmux), 64'(e.rmux));
      chk($sformatf("v%0d_alu_cin", idx), 64'(cin), 64'(e.cin));
    end
    if (e.chk_lr[1]) chk($sformatf("v%0d_reg_l", idx), 64'(l), 64'(e.l));
    if (e.chk_lr[0]) chk($sformatf("v%0d_reg_r", idx), 64'(r), 64'(e.r));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    rst = 1'b1; instr_ack = 1'b0; instr = '0; alu_flags = '0; mem_ack = 1'b0;

    //            instr                                   flags  ack alu mode rm cin lr    l     r     we    mi mw mrq inc ie cyc
    tbl[0]  = mk(enc(4'h3, 4'h0, 3'd2, 3'd0, 1'b0, 16'h1234), 8'h00, 0, 1, 4'hF, 1, 0, 2'b00, 4'd0, 4'd0, 8'h04, 0, 0, 0,  1, 0, 2);
    tbl[1]  = mk(enc(4'h1, 4'h0, 3'd2, 3'd2, 1'b0, 16'h0000), 8'h02, 0, 1, 4'h0, 0, 0, 2'b11, 4'd2, 4'd2, 8'h04, 0, 0, 0,  1, 0, 2);
    tbl[2]  = mk(enc(4'h7, 4'h1, 3'd0, 3'd5, 1'b0, 16'h0010), 8'h00, 0, 1, 4'h0, 1, 0, 2'b10, 4'd5, 4'd0, 8'h00, 0, 0, 0,  0, 1, 2);
    tbl[3]  = mk(enc(4'h7, 4'h1, 3'd0, 3'd5, 1'b1, 16'h0010), 8'h00, 0, 1, 4'h0, 1, 0, 2'b10, 4'd5, 4'd0, 8'h00, 0, 0, 0,  1, 0, 2);
    tbl[4]  = mk(enc(4'h1, 4'h3, 3'd1, 3'd4, 1'b1, 16'h0000), 8'h01, 0, 1, 4'h3, 0, 0, 2'b11, 4'd1, 4'd4, 8'h02, 0, 0, 0,  1, 0, 2);
    tbl[5]  = mk(enc(4'h2, 4'h5, 3'd6, 3'd7, 1'b1, 16'h00FF), 8'h00, 0, 1, 4'h5, 1, 1, 2'b10, 4'd7, 4'd0, 8'h40, 0, 0, 0,  1, 0, 2);
    tbl[6]  = mk(enc(4'h0, 4'h0, 3'd0, 3'd0, 1'b0, 16'h0000), 8'h00, 0, 0, 4'h0, 0, 0, 2'b00, 4'd0, 4'd0, 8'h00, 0, 0, 0,  1, 0, 2);
    tbl[7]  = mk(enc(4'h4, 4'h0, 3'd3, 3'd1, 1'b0, 16'h0004), 8'h00, 2, 1, 4'h0, 1, 0, 2'b10, 4'd1, 4'd0, 8'h08, 1, 0, 3,  1, 0, 4);
    tbl[8]  = mk(enc(4'h5, 4'h0, 3'd5, 3'd2, 1'b0, 16'h0008), 8'h00, 1, 1, 4'h0, 1, 0, 2'b11, 4'd2, 4'd5, 8'h00, 0, 1, 2,  1, 0, 3);
    tbl[9]  = mk(enc(4'h6, 4'h0, 3'd0, 3'd3, 1'b0, 16'h0020), 8'h00, 0, 1, 4'h0, 1, 0, 2'b10, 4'd3, 4'd0, 8'h00, 0, 0, 0,  0, 1, 2);
    tbl[10] = mk(enc(4'h5, 4'h0, 3'd1, 3'd6, 1'b0, 16'h0040), 8'h00, 0, 1, 4'h0, 1, 0, 2'b11, 4'd6, 4'd1, 8'h00, 0, 1, 16, 1, 0, 17);
    tbl[11] = mk(enc(4'hA, 4'h0, 3'd4, 3'd0, 1'b0, 16'h0000), 8'h00, 0, 0, 4'h0, 0, 0, 2'b00, 4'd0, 4'd0, 8'h00, 0, 0, 0,  1, 0, 2);
    tbl[12] = mk(enc(4'h4, 4'h0, 3'd7, 3'd0, 1'b0, 16'h0000), 8'h00, 1, 1, 4'h0, 1, 0, 2'b10, 4'd0, 4'd0, 8'h80, 1, 0, 2,  1, 0, 3);

    // Reset held three cycles with both acks high
    #3;
    rst = 1'b0; instr_ack = 1'b1; mem_ack = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", outs, 64'd0);
    release_rst();

    for (int i = 0; i < NV; i++) run_vec(tbl[i], i);
    chk("sticky_after_table", 64'({halted, err_illegal, err_bus}), 64'b011);

    // Reset asserted in the middle of a data access
    wait_req(ok);
    instr = enc(4'h4, 4'h0, 3'd1, 3'd2, 1'b0, 16'h0003);
    instr_ack = 1'b1;
    @(posedge clk); #1;
    instr_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_mem_req", 64'(mem_req), 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_mem_reset_outputs", outs, 64'd0);
    repeat (2) @(posedge clk);
    release_rst();

    // HALT: no PC change, then halted with no further fetch even with instr_ack high
    wait_req(ok);
    instr = enc(4'h8, 4'h0, 3'd0, 3'd0, 1'b0, 16'h0000);
    instr_ack = 1'b1;
    @(negedge clk); #1;
    chk("halt_exec", 64'({pc_inc, pc_ie, gp_reg_ie, halted}), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk($sformatf("halt_hold%0d", k), 64'({halted, instr_req, pc_inc, pc_ie, mem_req}), 64'b10000);
    end
    instr_ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
